// File: rtl/enc_ctrl_pkg.sv
// Shared encodings for the encoder channel controller.
//   mode_t      : SELECT (steps move the channel cursor) / EDIT (steps change the value)
//   btn_state_t : button classifier states
package enc_ctrl_pkg;

  typedef enum logic {
    SELECT = 1'b0,
    EDIT   = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_PRESS = 2'd1,
    B_LONG  = 2'd2
  } btn_state_t;

endpackage

// File: rtl/btn_press_classifier.sv
// Classifies a debounced button into short and long presses.
//   CLK, RST  : clock, async active-high reset
//   btn       : debounced level, 1 = pressed
//   short_evt : one-cycle pulse, released before the long threshold
//   long_evt  : one-cycle pulse, held for LONG_CYC cycles (once per press)
//   busy      : a press is in progress; the channel logic ignores steps then
// Both events are combinational in the cycle they are decided so the
// consumer's registers see them with one cycle of total latency.
module btn_press_classifier
  import enc_ctrl_pkg::*;
#(
  parameter int LONG_CYC = 16000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic short_evt,
  output logic long_evt,
  output logic busy
);

  localparam int CW = $clog2(LONG_CYC);
  localparam logic [CW-1:0] LAST = CW'(LONG_CYC - 1);

  btn_state_t      st, st_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            btn_q;

  // btn_q resets high: a button held through reset must be released and
  // pressed again before it counts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st    <= B_IDLE;
      cnt   <= '0;
      btn_q <= 1'b1;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      btn_q <= btn;
    end
  end

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    short_evt = 1'b0;
    long_evt  = 1'b0;
    case (st)
      B_IDLE: begin
        if (btn && !btn_q) begin
          st_nxt  = B_PRESS;
          cnt_nxt = '0;
        end
      end
      B_PRESS: begin
        if (!btn) begin
          short_evt = 1'b1;
          st_nxt    = B_IDLE;
        end else if (cnt == LAST) begin
          long_evt = 1'b1;
          st_nxt   = B_LONG;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      B_LONG: begin
        if (!btn) st_nxt = B_IDLE;
      end
      default: st_nxt = B_IDLE;
    endcase
  end

  assign busy = (st != B_IDLE);

endmodule

// File: rtl/enc_channel_ctrl.sv
// Rotary-encoder channel controller: N_CH value registers of W bits,
// navigated in SELECT mode and modified in EDIT mode. A short press toggles
// the mode, a long press clears the selected channel.
//   CLK, RST : clock, async active-high reset
//   I_STEP   : one-cycle step pulse;  I_CW : 1 = +1, 0 = -1
//   I_BTN    : debounced button level
//   O_VALUE  : value of the selected channel (registered)
//   O_CH     : selected channel index (registered)
//   O_EDIT   : 1 = EDIT mode
//   O_EVT    : one-cycle pulse after a channel value actually changed
module enc_channel_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 4,
  parameter int LONG_CYC = 16000000,
  parameter int WRAP     = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    I_STEP,
  input  logic                    I_CW,
  input  logic                    I_BTN,
  output logic [W-1:0]            O_VALUE,
  output logic [$clog2(N_CH)-1:0] O_CH,
  output logic                    O_EDIT,
  output logic                    O_EVT
);

  localparam int CHW = $clog2(N_CH);
  localparam logic [CHW-1:0] CH_LAST = CHW'(N_CH - 1);
  localparam logic [W-1:0]   VMAX    = '1;

  logic [N_CH-1:0][W-1:0] vals, vals_nxt;
  logic [CHW-1:0]         ch_nxt;
  logic [W-1:0]           cur, nv;
  logic                   chg;
  mode_t                  mode;
  logic                   short_evt, long_evt, busy;

  btn_press_classifier #(.LONG_CYC(LONG_CYC)) u_btn (
    .CLK       (CLK),
    .RST       (RST),
    .btn       (I_BTN),
    .short_evt (short_evt),
    .long_evt  (long_evt),
    .busy      (busy)
  );

  // Long event has priority; steps are only honoured with the button idle,
  // which also drops a step coinciding with the long event.
  always_comb begin
    vals_nxt = vals;
    ch_nxt   = O_CH;
    chg      = 1'b0;
    cur      = vals[O_CH];
    nv       = cur;
    if (long_evt) begin
      vals_nxt[O_CH] = '0;
      chg            = (cur != '0);
    end else if (I_STEP && !busy) begin
      if (mode == SELECT) begin
        if (I_CW) ch_nxt = (O_CH == CH_LAST) ? '0 : O_CH + 1'b1;
        else      ch_nxt = (O_CH == '0) ? CH_LAST : O_CH - 1'b1;
      end else begin
        if (I_CW) nv = (cur == VMAX && WRAP == 0) ? cur : cur + 1'b1;
        else      nv = (cur == '0   && WRAP == 0) ? cur : cur - 1'b1;
        vals_nxt[O_CH] = nv;
        chg            = (nv != cur);
      end
    end
  end

  // O_VALUE is loaded from the next-state view so it moves together with
  // O_CH and never shows the previous channel's value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vals    <= '0;
      O_CH    <= '0;
      O_VALUE <= '0;
      O_EVT   <= 1'b0;
      mode    <= SELECT;
    end else begin
      vals    <= vals_nxt;
      O_CH    <= ch_nxt;
      O_VALUE <= vals_nxt[ch_nxt];
      O_EVT   <= chg;
      if (short_evt) mode <= (mode == SELECT) ? EDIT : SELECT;
    end
  end

  assign O_EDIT = (mode == EDIT);

endmodule

// File: tb/tb_enc_channel_ctrl.sv
// Bench for enc_channel_ctrl. Two instances share stimulus: dut_w (WRAP=1)
// is tracked by a model plus an event scoreboard, dut_s (WRAP=0) by
// explicit expectations at the saturation points.
module tb_enc_channel_ctrl;

  localparam int N_CH = 4;
  localparam int W    = 4;
  localparam int LC   = 8;

  typedef struct {
    int cyc;
    int ch;
    int val;
  } exp_t;

  logic CLK = 1'b0, RST = 1'b1, I_STEP = 1'b0, I_CW = 1'b0, I_BTN = 1'b0;
  logic [W-1:0] val_w, val_s;
  logic [1:0]   ch_w, ch_s;
  logic         edit_w, edit_s, evt_w, evt_s;

  int checks = 0, errs = 0, cyc = 0, n_evt_s = 0, n_pop = 0;
  int m_ch, m_edit;
  int m_val [N_CH];
  exp_t sbq[$];
  exp_t e;

  always #5 CLK = ~CLK;

  enc_channel_ctrl #(.N_CH(N_CH), .W(W), .LONG_CYC(LC), .WRAP(1)) dut_w (
    .CLK(CLK), .RST(RST), .I_STEP(I_STEP), .I_CW(I_CW), .I_BTN(I_BTN),
    .O_VALUE(val_w), .O_CH(ch_w), .O_EDIT(edit_w), .O_EVT(evt_w)
  );

  enc_channel_ctrl #(.N_CH(N_CH), .W(W), .LONG_CYC(LC), .WRAP(0)) dut_s (
    .CLK(CLK), .RST(RST), .I_STEP(I_STEP), .I_CW(I_CW), .I_BTN(I_BTN),
    .O_VALUE(val_s), .O_CH(ch_s), .O_EDIT(edit_s), .O_EVT(evt_s)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Every dut_w event must match the oldest outstanding expectation,
  // including the cycle it was due in.
  always @(negedge CLK) begin
    if (evt_s === 1'b1) n_evt_s++;
    if (evt_w === 1'b1) begin
      if (sbq.size() == 0) chk("evt_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        n_pop++;
        chk("evt_cyc", cyc, e.cyc);
        chk("evt_ch", ch_w, e.ch);
        chk("evt_val", val_w, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_ch   = 0;
    m_edit = 0;
    foreach (m_val[i]) m_val[i] = 0;
  endtask

  task automatic do_step(input logic cw);
    I_STEP = 1'b1;
    I_CW   = cw;
    if (m_edit == 0) m_ch = cw ? (m_ch + 1) % N_CH : (m_ch + N_CH - 1) % N_CH;
    else begin
      m_val[m_ch] = (m_val[m_ch] + (cw ? 1 : 15)) % 16;
      sbq.push_back('{cyc + 1, m_ch, m_val[m_ch]});
    end
    tick();
    I_STEP = 1'b0;
  endtask

  task automatic short_press(input int n);
    I_BTN = 1'b1;
    repeat (n) tick();
    I_BTN = 1'b0;
    tick();
    m_edit ^= 1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_ch"}, ch_w, m_ch);
    chk({tag, "_val"}, val_w, m_val[m_ch]);
    chk({tag, "_edit"}, edit_w, m_edit);
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    chk("rst_ch", ch_w, 0);
    chk("rst_val", val_w, 0);
    chk("rst_edit", edit_w, 0);
    chk("rst_evt", evt_w, 0);
    chk("rst_val_s", val_s, 0);
    RST = 1'b0;
    tick();

    // SELECT walk with modulo wrap, no value events
    repeat (3) do_step(1'b1);
    chk("sel_ch3", ch_w, 3);
    do_step(1'b1);
    chk("sel_wrap_ch", ch_w, 0);
    chk("sel_wrap_ch_s", ch_s, 0);
    chk("sel_val", val_w, 0);
    tick();
    chk("sel_no_evt", n_pop, 0);
    chk("sel_no_evt_s", n_evt_s, 0);

    // short press into EDIT, five increments on channel 0
    short_press(3);
    chk("edit_on", edit_w, 1);
    repeat (5) do_step(1'b1);
    tick();
    chk("edit_val", val_w, 5);
    chk("edit_val_s", val_s, 5);
    chk("edit_pops", n_pop, 5);
    chk("edit_evt_s", n_evt_s, 5);

    // top bound: wrap vs saturate
    repeat (10) do_step(1'b1);
    tick();
    chk("top_val", val_w, 15);
    chk("top_val_s", val_s, 15);
    do_step(1'b1);
    tick();
    chk("top_wrap", val_w, 0);
    chk("top_sat_s", val_s, 15);
    chk("top_sat_noevt_s", n_evt_s, 15);

    // bottom bound on channel 1
    short_press(3);
    do_step(1'b1);
    chk("ch1_sel", ch_w, 1);
    chk("ch1_sel_s", ch_s, 1);
    short_press(3);
    do_step(1'b0);
    tick();
    chk("bot_wrap", val_w, 15);
    chk("bot_sat_s", val_s, 0);
    repeat (6) do_step(1'b0);
    tick();
    check_outs("ch1_nine");
    chk("bot_sat_noevt_s", n_evt_s, 15);

    // long press: step during the press ignored, step on the long cycle dropped
    I_BTN = 1'b1;
    tick();
    repeat (3) tick();
    I_STEP = 1'b1; I_CW = 1'b1;
    tick();
    I_STEP = 1'b0;
    repeat (3) tick();
    I_STEP = 1'b1; I_CW = 1'b1;
    m_val[m_ch] = 0;
    sbq.push_back('{cyc + 1, m_ch, 0});
    tick();
    I_STEP = 1'b0;
    check_outs("long_clr");
    chk("long_clr_s", val_s, 0);
    repeat (3) tick();
    I_BTN = 1'b0;
    repeat (2) tick();
    chk("long_no_toggle", edit_w, 1);
    chk("clr_zero_noevt_s", n_evt_s, 15);

    // non-selected channels retained
    short_press(3);
    do_step(1'b0);
    check_outs("ret_ch0");
    chk("ret_ch0_s", val_s, 15);
    do_step(1'b1);
    check_outs("ret_ch1");

    // button held through reset release
    I_BTN = 1'b1;
    RST   = 1'b1;
    tick();
    model_reset();
    RST = 1'b0;
    repeat (3) tick();
    I_BTN = 1'b0;
    repeat (2) tick();
    chk("held_rst_no_toggle", edit_w, 0);
    short_press(3);
    chk("post_rst_edit", edit_w, 1);
    do_step(1'b1);
    tick();
    chk("post_rst_val", val_w, 1);
    chk("post_rst_val_s", val_s, 1);
    chk("post_rst_evt_s", n_evt_s, 16);

    // reset mid-press at counter 4: asynchronous, press abandoned
    I_BTN = 1'b1;
    tick();
    repeat (4) tick();
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_edit", edit_w, 0);
    chk("mid_rst_val", val_w, 0);
    chk("mid_rst_ch", ch_w, 0);
    chk("mid_rst_evt", evt_w, 0);
    chk("mid_rst_val_s", val_s, 0);
    model_reset();
    tick();
    RST = 1'b0;
    repeat (2) tick();
    I_BTN = 1'b0;
    repeat (3) tick();
    check_outs("mid_rst_after");

    chk("sb_empty", sbq.size(), 0);
    chk("sb_pops", n_pop, 25);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
